iseq_multi_dispatcher: RTL and testbench
========================================

ISEQ_MULTI_DISPATCHER -- requirements
Module: iseq_multi_dispatcher

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of instruction FIFO channels (1..8).
REQ-002 SHALL have parameter INSTR_W, default 32, meaning instruction word width.
REQ-003 SHALL have parameter ARB_MODE, default 0, meaning 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 SHALL be clocked by one clock and reset asynchronously, active-low: clk input 1 (rising edge), then rst_n input 1 (asynchronous, active-low).
REQ-005 process_iseq  input  1  start pulse for a dispatch run.
REQ-006 periodic_read_lock  input  1  when high, no new FIFO read or grant.
REQ-007 fifo_empty  input  NUM_CH  per-channel empty flag, first-word-fall-through FIFOs.
REQ-008 fifo_data  input  NUM_CH*INSTR_W  per-channel head word, channel c at bits [c*INSTR_W +: INSTR_W].
REQ-009 fifo_rd  output  NUM_CH  one-hot read strobe, at most one bit high.
REQ-010 instr_valid  output  1  output register holds an instruction.
REQ-011 instr_data  output  INSTR_W  instruction to instr_dispatcher.
REQ-012 instr_ch  output  CH_ID_W  source channel of instr_data.
REQ-013 instr_ack  input  1  downstream accepts when instr_valid & instr_ack.
REQ-014 dispatcher_busy  output  1  high in RUN or DRAIN.
REQ-015 run_done  output  1  one-cycle pulse on DRAIN->IDLE.
REQ-016 instr_count  output  16  instructions accepted downstream in the current or last run.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on process_iseq; process_iseq outside IDLE ignored.
REQ-018 In RUN, eligible = ~fifo_empty masked to zero when periodic_read_lock=1; a grant SHALL occur when eligible!=0 and the output register is empty or is handshaking this cycle.
REQ-019 On grant to channel c: fifo_rd[c]=1 that cycle; fifo_data[c] and c load into instr_data/instr_ch and instr_valid=1 on the next edge (1-cycle latency, full throughput of 1 word/cycle).
REQ-020 ARB_MODE=0: grant the first eligible channel after last_grant cyclically (wrap NUM_CH-1 -> 0); last_grant updates only on a grant; reset value NUM_CH-1, so channel 0 wins first.
REQ-021 ARB_MODE=1: grant lowest-indexed eligible channel; last_grant unused.
REQ-022 RUN->DRAIN when all fifo_empty=1 and no grant this cycle; lock alone SHALL NOT leave RUN.
REQ-023 DRAIN->IDLE when instr_valid=0 or instr_valid&instr_ack; run_done=1 in the cycle after that transition edge (registered).
REQ-024 instr_valid SHALL hold with stable instr_data/instr_ch until instr_ack; handshake without new grant clears instr_valid.
REQ-025 fifo_rd SHALL be zero in IDLE and DRAIN; a FIFO becoming non-empty in DRAIN is not read until the next run.
REQ-026 process_iseq with all FIFOs empty: IDLE->RUN->DRAIN->IDLE, run_done after 3 cycles, instr_count=0.

Reset
REQ-027 rst_n low SHALL force state IDLE, instr_valid=0, instr_data=0, instr_ch=0, fifo_rd=0, dispatcher_busy=0, run_done=0, instr_count=0, last_grant=NUM_CH-1, immediately and regardless of clk; an in-flight instruction is discarded.

Configuration
REQ-028 Macro ISEQ_DISP_COUNT_EN defined: instr_count clears on IDLE->RUN, increments on each instr_valid&instr_ack, saturates at 0xFFFF; undefined: counter not built, instr_count tied to 0.

Structure
REQ-029 Package iseq_disp_pkg SHALL hold the state enum (IDLE, RUN, DRAIN), ARB_RR/ARB_FIXED constants and CH_ID_W = max(1, clog2(NUM_CH)) function.
REQ-030 Arbitration SHALL live in sub-module iseq_rr_arbiter (request vector, last_grant, mode -> one-hot grant, grant index).

Verification
REQ-031 NUM_CH=2, RR, ch0 holds A0,A1, ch1 holds B0,B1, ack always 1, pulse start -> output order A0,B0,A1,B1 on 4 consecutive cycles, run_done, instr_count=4.
REQ-032 ARB_MODE=1, same data -> order A0,A1,B0,B1.
REQ-033 ack held 0 for 3 cycles with valid=1 -> instr_data stable, fifo_rd=0 during stall, no word lost or duplicated.
REQ-034 periodic_read_lock=1 for 5 cycles mid-run -> fifo_rd=0, state stays RUN, resumes with next RR channel after lock drops.
REQ-035 rst_n low while instr_valid=1 in RUN -> all outputs zero asynchronously; next start from channel 0.
REQ-036 start with all FIFOs empty -> busy 2 cycles, run_done 1 pulse, instr_count=0; second start pulse during RUN ignored.

Source files
------------

// File: rtl/iseq_disp_pkg.sv
// Shared types and helpers for the instruction-sequence multi-channel dispatcher.
package iseq_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } disp_state_e;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;
  localparam int unsigned COUNT_W   = 16;

  // Channel-index width; a single channel still needs one bit of index.
  function automatic int unsigned ch_id_w(input int unsigned num_ch);
    return (num_ch > 1) ? int'($clog2(num_ch)) : 1;
  endfunction

endpackage

// File: rtl/iseq_rr_arbiter.sv
// Channel arbiter: round-robin after last_grant, or fixed lowest-index priority.
module iseq_rr_arbiter
  import iseq_disp_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned CH_ID_W = 1
) (
  input  logic [NUM_CH-1:0]  req_i,
  input  logic [CH_ID_W-1:0] last_grant_i,
  input  logic               mode_i,
  output logic [NUM_CH-1:0]  gnt_o,
  output logic [CH_ID_W-1:0] gnt_idx_o,
  output logic               gnt_valid_o
);

  int unsigned        cand;
  logic [CH_ID_W-1:0] cand_idx;
  logic               found;

  // Scan candidates in priority order and take the first requester
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    found       = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (mode_i == 1'(ARB_FIXED)) begin
        cand = i;
      end else begin
        cand = 32'(last_grant_i) + i + 1;
        if (cand >= NUM_CH) cand = cand - NUM_CH;
      end
      cand_idx = cand[CH_ID_W-1:0];
      if (!found && req_i[cand_idx]) begin
        found            = 1'b1;
        gnt_idx_o        = cand_idx;
        gnt_o[cand_idx]  = 1'b1;
      end
    end
    gnt_valid_o = found;
  end

endmodule

// File: rtl/iseq_multi_dispatcher.sv
// Multi-FIFO instruction dispatcher: arbitrates FWFT instruction FIFOs into one
// registered valid/ack output stream per run. Optional macro ISEQ_DISP_COUNT_EN
// builds the accepted-instruction counter; otherwise instr_count reads zero.
module iseq_multi_dispatcher
  import iseq_disp_pkg::*;
#(
  parameter  int unsigned NUM_CH   = 2,
  parameter  int unsigned INSTR_W  = 32,
  parameter  int unsigned ARB_MODE = 0,
  localparam int unsigned CH_ID_W  = ch_id_w(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      process_iseq,
  input  logic                      periodic_read_lock,
  input  logic [NUM_CH-1:0]         fifo_empty,
  input  logic [NUM_CH*INSTR_W-1:0] fifo_data,
  output logic [NUM_CH-1:0]         fifo_rd,
  output logic                      instr_valid,
  output logic [INSTR_W-1:0]        instr_data,
  output logic [CH_ID_W-1:0]        instr_ch,
  input  logic                      instr_ack,
  output logic                      dispatcher_busy,
  output logic                      run_done,
  output logic [COUNT_W-1:0]        instr_count
);

  disp_state_e        state_q, state_d;
  logic               valid_q;
  logic [INSTR_W-1:0] data_q;
  logic [CH_ID_W-1:0] ch_q;
  logic [CH_ID_W-1:0] last_q;
  logic               busy_q;
  logic               done_q;

  logic [NUM_CH-1:0]  req;
  logic [NUM_CH-1:0]  gnt;
  logic [CH_ID_W-1:0] gnt_idx;
  logic               gnt_any;
  logic               grant;
  logic               handshake;
  logic [INSTR_W-1:0] head [NUM_CH];

  assign handshake = valid_q & instr_ack;

  // Only channels with data are eligible, and only while running and unlocked
  always_comb begin
    req = '0;
    if (state_q == RUN && !periodic_read_lock) req = ~fifo_empty;
  end

  iseq_rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .CH_ID_W (CH_ID_W)
  ) u_arb (
    .req_i        (req),
    .last_grant_i (last_q),
    .mode_i       (1'(ARB_MODE)),
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx),
    .gnt_valid_o  (gnt_any)
  );

  // A grant needs room in the output register, either empty or emptying now
  assign grant   = gnt_any & (~valid_q | instr_ack);
  assign fifo_rd = grant ? gnt : '0;

  // Split the flat head-word bus into per-channel words
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      head[c] = fifo_data[c*INSTR_W +: INSTR_W];
    end
  end

  // Run sequencing: leave RUN only once every FIFO is empty, not on lock
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (process_iseq) state_d = RUN;
      RUN:     if (&fifo_empty && !grant) state_d = DRAIN;
      DRAIN:   if (!valid_q || instr_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, output register and arbitration history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      last_q  <= CH_ID_W'(NUM_CH - 1);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == DRAIN) && (state_d == IDLE);
      if (grant) begin
        valid_q <= 1'b1;
        data_q  <= head[gnt_idx];
        ch_q    <= gnt_idx;
        last_q  <= gnt_idx;
      end else if (handshake) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign instr_valid     = valid_q;
  assign instr_data      = data_q;
  assign instr_ch        = ch_q;
  assign dispatcher_busy = busy_q;
  assign run_done        = done_q;

`ifdef ISEQ_DISP_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  // Accepted-instruction counter, restarted per run and held at full scale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (state_q == IDLE && process_iseq) begin
      count_q <= '0;
    end else if (handshake && count_q != '1) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_iseq_multi_dispatcher.sv
// Bench for iseq_multi_dispatcher: a round-robin and a fixed-priority instance
// share control stimulus, each with its own FIFO environment and scoreboard.
module tb_iseq_multi_dispatcher;

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CH_ID_W = 1;
  localparam int          NDUT    = 2;
  localparam int          M_IDLE  = 0;
  localparam int          M_RUN   = 1;
  localparam int          M_DRAIN = 2;

  typedef struct packed {
    logic [CH_ID_W-1:0] ch;
    logic [INSTR_W-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic process_iseq       = 1'b0;
  logic periodic_read_lock = 1'b0;
  logic instr_ack          = 1'b0;

  logic [NUM_CH-1:0]         fifo_empty      [NDUT];
  logic [NUM_CH*INSTR_W-1:0] fifo_data       [NDUT];
  logic [NUM_CH-1:0]         fifo_rd         [NDUT];
  logic                      instr_valid     [NDUT];
  logic [INSTR_W-1:0]        instr_data      [NDUT];
  logic [CH_ID_W-1:0]        instr_ch        [NDUT];
  logic                      dispatcher_busy [NDUT];
  logic                      run_done        [NDUT];
  logic [15:0]               instr_count     [NDUT];

  always #5 clk = ~clk;

  iseq_multi_dispatcher #(.NUM_CH(NUM_CH), .INSTR_W(INSTR_W), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .process_iseq(process_iseq),
    .periodic_read_lock(periodic_read_lock),
    .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]), .fifo_rd(fifo_rd[0]),
    .instr_valid(instr_valid[0]), .instr_data(instr_data[0]), .instr_ch(instr_ch[0]),
    .instr_ack(instr_ack), .dispatcher_busy(dispatcher_busy[0]),
    .run_done(run_done[0]), .instr_count(instr_count[0]));

  iseq_multi_dispatcher #(.NUM_CH(NUM_CH), .INSTR_W(INSTR_W), .ARB_MODE(1)) u_fix (
    .clk(clk), .rst_n(rst_n), .process_iseq(process_iseq),
    .periodic_read_lock(periodic_read_lock),
    .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]), .fifo_rd(fifo_rd[1]),
    .instr_valid(instr_valid[1]), .instr_data(instr_data[1]), .instr_ch(instr_ch[1]),
    .instr_ack(instr_ack), .dispatcher_busy(dispatcher_busy[1]),
    .run_done(run_done[1]), .instr_count(instr_count[1]));

  int n_tests = 0;
  int n_fail  = 0;

  // Environment FIFOs, scoreboards and accepted-word logs
  logic [INSTR_W-1:0] fq  [NDUT][NUM_CH][$];
  exp_t               sb  [NDUT][$];
  logic [INSTR_W-1:0] acc [NDUT][$];

  // Reference model state
  int          m_state [NDUT];
  int          m_last  [NDUT];
  bit          m_valid [NDUT];
  bit          m_done  [NDUT];
  int          m_count [NDUT];
  int          gch     [NDUT];
  bit          aempty  [NDUT];
  logic [NUM_CH-1:0] rd_seen [NDUT];
  int          busy_cycles [NDUT];
  int          done_pulses [NDUT];

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_state[d] = M_IDLE;
      m_last[d]  = int'(NUM_CH) - 1;
      m_valid[d] = 1'b0;
      m_done[d]  = 1'b0;
      m_count[d] = 0;
      sb[d].delete();
    end
  endtask

  task automatic drive_fifos();
    for (int d = 0; d < NDUT; d++) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        fifo_empty[d][c] = (fq[d][c].size() == 0);
        fifo_data[d][c*INSTR_W +: INSTR_W] = (fq[d][c].size() != 0) ? fq[d][c][0] : 32'hDEAD_BEEF;
      end
    end
  endtask

  task automatic load(input int c, input logic [INSTR_W-1:0] w);
    for (int d = 0; d < NDUT; d++) fq[d][c].push_back(w);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      chk({tag, "_valid"}, d, 64'(instr_valid[d]), 64'(0));
      chk({tag, "_data"},  d, 64'(instr_data[d]),  64'(0));
      chk({tag, "_ch"},    d, 64'(instr_ch[d]),    64'(0));
      chk({tag, "_rd"},    d, 64'(fifo_rd[d]),     64'(0));
      chk({tag, "_busy"},  d, 64'(dispatcher_busy[d]), 64'(0));
      chk({tag, "_done"},  d, 64'(run_done[d]),    64'(0));
      chk({tag, "_count"}, d, 64'(instr_count[d]), 64'(0));
    end
  endtask

  // One clock of stimulus with model prediction and cycle-level checks
  task automatic step(input bit start, input bit lock, input bit ack);
    int   exp_cnt;
    bit   hs;
    exp_t e;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
`ifdef ISEQ_DISP_COUNT_EN
      exp_cnt = m_count[d];
`else
      exp_cnt = 0;
`endif
      chk("busy",     d, 64'(dispatcher_busy[d]), 64'(m_state[d] != M_IDLE));
      chk("run_done", d, 64'(run_done[d]),    64'(m_done[d]));
      chk("valid",    d, 64'(instr_valid[d]), 64'(m_valid[d]));
      chk("count",    d, 64'(instr_count[d]), 64'(exp_cnt));
      if (dispatcher_busy[d]) busy_cycles[d]++;
      if (run_done[d]) done_pulses[d]++;
    end
    process_iseq       = start;
    periodic_read_lock = lock;
    instr_ack          = ack;
    drive_fifos();
    #1;
    for (int d = 0; d < NDUT; d++) begin
      gch[d]    = -1;
      aempty[d] = 1'b1;
      for (int c = 0; c < int'(NUM_CH); c++) if (fq[d][c].size() != 0) aempty[d] = 1'b0;
      if (m_state[d] == M_RUN && !lock && (!m_valid[d] || ack)) begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
          int c;
          c = (d == 0) ? (m_last[d] + 1 + k) % int'(NUM_CH) : k;
          if (gch[d] < 0 && fq[d][c].size() != 0) gch[d] = c;
        end
      end
      chk("fifo_rd", d, 64'(fifo_rd[d]), (gch[d] >= 0) ? (64'(1) << gch[d]) : 64'(0));
      rd_seen[d] = fifo_rd[d];
      if (gch[d] >= 0) begin
        e.ch   = CH_ID_W'(gch[d]);
        e.data = fq[d][gch[d]][0];
        sb[d].push_back(e);
      end
    end
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      hs = m_valid[d] && ack;
      m_done[d] = 1'b0;
      case (m_state[d])
        M_IDLE:  if (start) begin m_state[d] = M_RUN; m_count[d] = 0; end
        M_RUN:   if (aempty[d] && gch[d] < 0) m_state[d] = M_DRAIN;
        default: if (!m_valid[d] || ack) begin m_state[d] = M_IDLE; m_done[d] = 1'b1; end
      endcase
      if (hs && m_count[d] != 65535) m_count[d]++;
      if (gch[d] >= 0) begin
        m_valid[d] = 1'b1;
        m_last[d]  = gch[d];
      end else if (hs) begin
        m_valid[d] = 1'b0;
      end
      for (int c = 0; c < int'(NUM_CH); c++)
        if (rd_seen[d][c] && fq[d][c].size() != 0) void'(fq[d][c].pop_front());
    end
  endtask

  task automatic run_until_idle(input int budget, input bit ack_val);
    int n;
    n = 0;
    while ((m_state[0] != M_IDLE || m_state[1] != M_IDLE) && n < budget) begin
      step(1'b0, 1'b0, ack_val);
      n++;
    end
    n_tests++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL idle_timeout: got %0d cycles expected fewer than %0d", n, budget);
    end
    step(1'b0, 1'b0, ack_val);
  endtask

  // Output monitor: displayed word must match the scoreboard head until accepted
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int d = 0; d < NDUT; d++) begin
        if (rst_n && instr_valid[d]) begin
          if (sb[d].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out dut%0d: got %0h expected none", d, instr_data[d]);
          end else begin
            chk("out_data", d, 64'(instr_data[d]), 64'(sb[d][0].data));
            chk("out_ch",   d, 64'(instr_ch[d]),   64'(sb[d][0].ch));
            if (instr_ack) begin
              acc[d].push_back(instr_data[d]);
              void'(sb[d].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    logic [INSTR_W-1:0] ord [NDUT][4];
    ord[0] = '{32'hA000_0000, 32'hB000_0000, 32'hA000_0001, 32'hB000_0001};
    ord[1] = '{32'hA000_0000, 32'hA000_0001, 32'hB000_0000, 32'hB000_0001};
    drive_fifos();
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    #4 rst_n = 1'b1;

    // Two-channel ordering run with ack always high
    for (int d = 0; d < NDUT; d++) acc[d].delete();
    load(0, 32'hA000_0000); load(0, 32'hA000_0001);
    load(1, 32'hB000_0000); load(1, 32'hB000_0001);
    step(1'b1, 1'b0, 1'b1);
    run_until_idle(50, 1'b1);
    for (int d = 0; d < NDUT; d++) begin
      chk("order_len", d, 64'(acc[d].size()), 64'(4));
      for (int i = 0; i < 4; i++)
        if (acc[d].size() > i) chk("order", d, 64'(acc[d][i]), 64'(ord[d][i]));
`ifdef ISEQ_DISP_COUNT_EN
      chk("count_run", d, 64'(instr_count[d]), 64'(4));
`else
      chk("count_run", d, 64'(instr_count[d]), 64'(0));
`endif
    end

    // Downstream stall for three cycles
    load(0, 32'h1000_0000); load(0, 32'h1000_0001); load(0, 32'h1000_0002);
    load(1, 32'h2000_0000); load(1, 32'h2000_0001);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    run_until_idle(50, 1'b1);

    // Read lock mid-run
    for (int i = 0; i < 4; i++) begin
      load(0, 32'h3000_0000 + 32'(i));
      load(1, 32'h4000_0000 + 32'(i));
    end
    step(1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b1);
    run_until_idle(50, 1'b1);

    // Asynchronous reset with an instruction in flight
    for (int i = 0; i < 3; i++) begin
      load(0, 32'h5000_0000 + 32'(i));
      load(1, 32'h6000_0000 + 32'(i));
    end
    step(1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    for (int d = 0; d < NDUT; d++) chk("pre_reset_valid", d, 64'(instr_valid[d]), 64'(1));
    @(negedge clk);
    #4 rst_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    #4 rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    run_until_idle(50, 1'b1);

    // Empty-FIFO run with a second start pulse while running
    for (int d = 0; d < NDUT; d++) begin
      for (int c = 0; c < int'(NUM_CH); c++) fq[d][c].delete();
      busy_cycles[d] = 0;
      done_pulses[d] = 0;
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    for (int d = 0; d < NDUT; d++) begin
      chk("empty_busy_cycles", d, 64'(busy_cycles[d]), 64'(2));
      chk("empty_done_pulses", d, 64'(done_pulses[d]), 64'(1));
    end

    // Randomized traffic
    repeat (1500) begin
      for (int d = 0; d < NDUT; d++)
        if ($urandom_range(0, 7) == 0)
          fq[d][$urandom_range(0, NUM_CH - 1)].push_back($urandom);
      step($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
    end
    run_until_idle(400, 1'b1);
    for (int d = 0; d < NDUT; d++) chk("sb_empty", d, 64'(sb[d].size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
